wdt_regif: RTL and testbench

WDT_REGIF -- requirements
Module: wdt_regif

---
 rtl/wdt_pkg.sv | 18 +
 rtl/wdt_kick_seq.sv | 69 ++++++
 rtl/wdt_regif.sv | 166 ++++++++++++++++
 tb/tb_wdt_regif.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared constants and state encodings for the watchdog register interface.
package wdt_pkg;

  localparam logic [2:0] ADDR_CNT_L  = 3'd0;
  localparam logic [2:0] ADDR_CNT_H  = 3'd1;
  localparam logic [2:0] ADDR_RLD_L  = 3'd2;
  localparam logic [2:0] ADDR_RLD_H  = 3'd3;
  localparam logic [2:0] ADDR_CFG    = 3'd4;
  localparam logic [2:0] ADDR_KICK   = 3'd5;
  localparam logic [2:0] ADDR_STATUS = 3'd6;

  localparam logic [7:0] KICK_ARM  = 8'h55;
  localparam logic [7:0] KICK_FIRE = 8'hAA;

  typedef enum logic {IDLE, ACK} bus_state_t;
  typedef enum logic {K_IDLE, K_ARMED} kick_state_t;

endpackage

// File: rtl/wdt_kick_seq.sv
// Two-step kick sequencer: 0x55 arms, 0xAA within KICK_TIMEOUT cycles fires.
module wdt_kick_seq
  import wdt_pkg::*;
#(
  parameter int unsigned KICK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       kick_wr,
  input  logic [7:0] kick_data,
  output logic       kick_ok,
  output logic       kick_fail,
  output logic       armed
);

  kick_state_t state;
  logic [7:0]  timer;

  assign armed = (state == K_ARMED);

  always_comb begin
    kick_ok   = 1'b0;
    kick_fail = 1'b0;
    case (state)
      K_IDLE: begin
        if (kick_wr && (kick_data != KICK_ARM)) kick_fail = 1'b1;
      end
      K_ARMED: begin
        if (kick_wr) begin
          if ((kick_data == KICK_FIRE) && (timer != '0)) kick_ok = 1'b1;
          else kick_fail = 1'b1;
        end else if (timer == '0) begin
          kick_fail = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Timer counts down from arm; a kick seen while it is still non-zero is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= K_IDLE;
      timer <= '0;
    end else begin
      case (state)
        K_IDLE: begin
          if (kick_wr && (kick_data == KICK_ARM)) begin
            state <= K_ARMED;
            timer <= 8'(KICK_TIMEOUT);
          end
        end
        K_ARMED: begin
          if (kick_ok || kick_fail) begin
            state <= K_IDLE;
            timer <= '0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        default: begin
          state <= K_IDLE;
          timer <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/wdt_regif.sv
// CPU register interface for the watchdog. Define WDT_LOCK_EN to enable the
// configuration lock (CFG write with bit0=1 freezes CFG/RLD/CNT writes until reset).
module wdt_regif
  import wdt_pkg::*;
#(
  parameter int unsigned KICK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        ready,
  input  logic [15:0] wd_counter_out,
  input  logic [15:0] wd_reload_out,
  input  logic [7:0]  wd_config_out,
  output logic [15:0] wd_counter_in,
  output logic [15:0] wd_reload_in,
  output logic [7:0]  wd_config_in,
  output logic [1:0]  wd_counter_write,
  output logic [1:0]  wd_reload_write,
  output logic        wd_config_write
);

  bus_state_t bus_state;
  logic       done;
  logic [7:0] shadow;
  logic [7:0] snapshot;
  logic       kick_err;
  logic       lock_err;
  logic       lock;
  logic       armed;
  logic       kick_ok;
  logic       kick_fail;
  logic       accept;
  logic       wr;
  logic       rd;
  logic       blocked;
  logic [7:0] rd_val;

  // done stops a still-held sel from starting a second access after ACK.
  assign accept = (bus_state == IDLE) && sel && !done;
  assign wr     = accept && we;
  assign rd     = accept && !we;

  wdt_kick_seq #(.KICK_TIMEOUT(KICK_TIMEOUT)) u_kick (
    .clk       (clk),
    .reset     (reset),
    .kick_wr   (wr && (addr == ADDR_KICK)),
    .kick_data (wdata),
    .kick_ok   (kick_ok),
    .kick_fail (kick_fail),
    .armed     (armed)
  );

`ifdef WDT_LOCK_EN
  always_ff @(posedge clk) begin
    if (reset) lock <= 1'b0;
    else if (wr && (addr == ADDR_CFG) && wdata[0]) lock <= 1'b1;
  end
`else
  assign lock = 1'b0;
`endif

  assign blocked = lock && wr &&
                   ((addr == ADDR_CFG) || (addr == ADDR_RLD_H) ||
                    (addr == ADDR_CNT_L) || (addr == ADDR_CNT_H));

  always_comb begin
    rd_val = '0;
    case (addr)
      ADDR_CNT_L:  rd_val = wd_counter_out[7:0];
      ADDR_CNT_H:  rd_val = snapshot;
      ADDR_CFG:    rd_val = wd_config_out;
      ADDR_STATUS: rd_val = {5'b0, lock_err, kick_err, armed};
      default:     rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus_state        <= IDLE;
      done             <= 1'b0;
      ready            <= 1'b0;
      rdata            <= '0;
      shadow           <= '0;
      snapshot         <= '0;
      kick_err         <= 1'b0;
      lock_err         <= 1'b0;
      wd_counter_in    <= '0;
      wd_reload_in     <= '0;
      wd_config_in     <= '0;
      wd_counter_write <= '0;
      wd_reload_write  <= '0;
      wd_config_write  <= 1'b0;
    end else begin
      wd_counter_in    <= '0;
      wd_reload_in     <= '0;
      wd_config_in     <= '0;
      wd_counter_write <= '0;
      wd_reload_write  <= '0;
      wd_config_write  <= 1'b0;

      case (bus_state)
        IDLE: begin
          if (!sel) done <= 1'b0;
          if (accept) begin
            bus_state <= ACK;
            ready     <= 1'b1;
            rdata     <= we ? 8'h00 : rd_val;
          end
        end
        ACK: begin
          bus_state <= IDLE;
          ready     <= 1'b0;
          rdata     <= '0;
          done      <= sel;
        end
        default: begin
          bus_state <= IDLE;
          ready     <= 1'b0;
          rdata     <= '0;
        end
      endcase

      if (rd && (addr == ADDR_CNT_L)) snapshot <= wd_counter_out[15:8];

      if (wr && !blocked) begin
        case (addr)
          ADDR_CNT_L: begin
            wd_counter_write <= 2'b01;
            wd_counter_in    <= {8'h00, wdata};
          end
          ADDR_CNT_H: begin
            wd_counter_write <= 2'b10;
            wd_counter_in    <= {wdata, 8'h00};
          end
          ADDR_RLD_L: shadow <= wdata;
          ADDR_RLD_H: begin
            wd_reload_write <= 2'b11;
            wd_reload_in    <= {wdata, shadow};
          end
          ADDR_CFG: begin
            wd_config_write <= 1'b1;
            wd_config_in    <= wdata;
          end
          default: ;
        endcase
      end

      if (kick_ok) begin
        wd_counter_write <= 2'b11;
        wd_counter_in    <= wd_reload_out;
      end

      // Set beats clear when a timer expiry coincides with a STATUS write.
      kick_err <= kick_fail ||
                  (kick_err && !(wr && (addr == ADDR_STATUS) && wdata[1]));
      lock_err <= blocked ||
                  (lock_err && !(wr && (addr == ADDR_STATUS) && wdata[2]));
    end
  end

endmodule

// File: tb/tb_wdt_regif.sv
// Directed self-checking bench for wdt_regif; lock tests follow WDT_LOCK_EN.
module tb_wdt_regif;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  addr = '0;
  logic [7:0]  wdata = '0;
  logic [7:0]  rdata;
  logic        ready;
  logic [15:0] wd_counter_out = '0;
  logic [15:0] wd_reload_out = '0;
  logic [7:0]  wd_config_out = '0;
  logic [15:0] wd_counter_in;
  logic [15:0] wd_reload_in;
  logic [7:0]  wd_config_in;
  logic [1:0]  wd_counter_write;
  logic [1:0]  wd_reload_write;
  logic        wd_config_write;

  int checks = 0;
  int errors = 0;

  int          n_cnt = 0, n_rld = 0, n_cfg = 0, n_multi = 0;
  logic [1:0]  last_cw, last_rw;
  logic [15:0] last_ci, last_ri;
  logic [7:0]  last_gi;

  localparam int unsigned TMO = 8;

  wdt_regif #(.KICK_TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready),
    .wd_counter_out(wd_counter_out), .wd_reload_out(wd_reload_out),
    .wd_config_out(wd_config_out),
    .wd_counter_in(wd_counter_in), .wd_reload_in(wd_reload_in),
    .wd_config_in(wd_config_in),
    .wd_counter_write(wd_counter_write), .wd_reload_write(wd_reload_write),
    .wd_config_write(wd_config_write)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wd_counter_write != 2'b00) begin
      n_cnt <= n_cnt + 1; last_cw <= wd_counter_write; last_ci <= wd_counter_in;
    end
    if (wd_reload_write != 2'b00) begin
      n_rld <= n_rld + 1; last_rw <= wd_reload_write; last_ri <= wd_reload_in;
    end
    if (wd_config_write) begin
      n_cfg <= n_cfg + 1; last_gi <= wd_config_in;
    end
    if (int'(|wd_counter_write) + int'(|wd_reload_write) + int'(wd_config_write) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic bus(input logic w, input logic [2:0] a, input logic [7:0] d,
                     output logic [7:0] rd);
    logic got;
    @(negedge clk);
    sel = 1'b1; we = w; addr = a; wdata = d;
    got = 1'b0; rd = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ready) begin got = 1'b1; rd = rdata; break; end
    end
    sel = 1'b0; we = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL bus_timeout addr=%0d ready never rose within 8 cycles", a);
    end
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b0 || rdata !== 8'h00 || wd_counter_write !== 2'b00 ||
        wd_reload_write !== 2'b00 || wd_config_write !== 1'b0 ||
        wd_counter_in !== 16'h0 || wd_reload_in !== 16'h0 || wd_config_in !== 8'h0) begin
      errors++;
      $display("FAIL reset_outputs ready=%b rdata=%h cw=%b rw=%b gw=%b ci=%h ri=%h gi=%h expected all 0",
               ready, rdata, wd_counter_write, wd_reload_write, wd_config_write,
               wd_counter_in, wd_reload_in, wd_config_in);
    end
    reset = 1'b0;
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_status got %h expected 00", r); end
    bus(1'b0, 3'd1, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_snapshot got %h expected 00", r); end
    settle();
    checks++;
    if (rdata !== 8'h00) begin errors++; $display("FAIL rdata_idle got %h expected 00", rdata); end
  endtask

  task automatic test_snapshot();
    logic [7:0] r;
    wd_counter_out = 16'h12FF;
    bus(1'b0, 3'd0, 8'h00, r);
    checks++;
    if (r !== 8'hFF) begin errors++; $display("FAIL cnt_l_read got %h expected FF", r); end
    wd_counter_out = 16'h1300;
    bus(1'b0, 3'd1, 8'h00, r);
    checks++;
    if (r !== 8'h12) begin errors++; $display("FAIL cnt_h_snapshot got %h expected 12", r); end
    bus(1'b0, 3'd7, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reserved_read got %h expected 00", r); end
  endtask

  task automatic test_reload();
    logic [7:0] r;
    int base;
    base = n_rld;
    bus(1'b1, 3'd2, 8'h34, r);
    settle();
    checks++;
    if (n_rld - base !== 0) begin errors++; $display("FAIL rld_l_no_strobe got %0d strobes expected 0", n_rld - base); end
    bus(1'b1, 3'd3, 8'hAB, r);
    settle();
    checks++;
    if (n_rld - base !== 1 || last_rw !== 2'b11 || last_ri !== 16'hAB34) begin
      errors++;
      $display("FAIL rld_h_strobe count=%0d wr=%b in=%h expected 1 11 AB34", n_rld - base, last_rw, last_ri);
    end
  endtask

  task automatic test_counter_write();
    logic [7:0] r;
    int base;
    base = n_cnt;
    bus(1'b1, 3'd0, 8'h5A, r);
    settle();
    checks++;
    if (n_cnt - base !== 1 || last_cw !== 2'b01 || last_ci[7:0] !== 8'h5A) begin
      errors++;
      $display("FAIL cnt_l_write count=%0d wr=%b in=%h expected 1 01 xx5A", n_cnt - base, last_cw, last_ci);
    end
    bus(1'b1, 3'd1, 8'hC3, r);
    settle();
    checks++;
    if (n_cnt - base !== 2 || last_cw !== 2'b10 || last_ci[15:8] !== 8'hC3) begin
      errors++;
      $display("FAIL cnt_h_write count=%0d wr=%b in=%h expected 2 10 C3xx", n_cnt - base, last_cw, last_ci);
    end
  endtask

  task automatic test_config();
    logic [7:0] r;
    int base;
    wd_config_out = 8'h3C;
    bus(1'b0, 3'd4, 8'h00, r);
    checks++;
    if (r !== 8'h3C) begin errors++; $display("FAIL cfg_read got %h expected 3C", r); end
    base = n_cfg;
    bus(1'b1, 3'd4, 8'h96, r);
    settle();
    checks++;
    if (n_cfg - base !== 1 || last_gi !== 8'h96) begin
      errors++;
      $display("FAIL cfg_write count=%0d in=%h expected 1 96", n_cfg - base, last_gi);
    end
  endtask

  task automatic test_kick_ok();
    logic [7:0] r;
    int base;
    wd_reload_out = 16'hF000;
    base = n_cnt;
    bus(1'b1, 3'd5, 8'h55, r);
    repeat (3) @(negedge clk);
    bus(1'b1, 3'd5, 8'hAA, r);
    settle();
    checks++;
    if (n_cnt - base !== 1 || last_cw !== 2'b11 || last_ci !== 16'hF000) begin
      errors++;
      $display("FAIL kick_fire count=%0d wr=%b in=%h expected 1 11 F000", n_cnt - base, last_cw, last_ci);
    end
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL kick_ok_status got %h expected 00", r); end
    bus(1'b0, 3'd5, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL kick_read got %h expected 00", r); end
  endtask

  // Arm is accepted at edge e0; the AA write lands on edge e(2+gap).
  task automatic test_kick_boundary();
    logic [7:0] r;
    int base;
    wd_reload_out = 16'h0BEE;
    base = n_cnt;
    bus(1'b1, 3'd5, 8'h55, r);
    repeat (TMO - 2) @(negedge clk);
    bus(1'b1, 3'd5, 8'hAA, r);
    settle();
    checks++;
    if (n_cnt - base !== 1 || last_ci !== 16'h0BEE) begin
      errors++;
      $display("FAIL kick_last_cycle count=%0d in=%h expected 1 0BEE", n_cnt - base, last_ci);
    end
    base = n_cnt;
    bus(1'b1, 3'd5, 8'h55, r);
    repeat (TMO - 1) @(negedge clk);
    bus(1'b1, 3'd5, 8'hAA, r);
    settle();
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (n_cnt - base !== 0 || r !== 8'h02) begin
      errors++;
      $display("FAIL kick_one_late count=%0d status=%h expected 0 02", n_cnt - base, r);
    end
    bus(1'b1, 3'd6, 8'h02, r);
  endtask

  task automatic test_timeout();
    logic [7:0] r;
    int base;
    base = n_cnt;
    bus(1'b1, 3'd5, 8'h55, r);
    repeat (TMO) @(negedge clk);
    bus(1'b1, 3'd5, 8'hAA, r);
    settle();
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (n_cnt - base !== 0 || r !== 8'h02) begin
      errors++;
      $display("FAIL kick_timeout count=%0d status=%h expected 0 02", n_cnt - base, r);
    end
    bus(1'b1, 3'd6, 8'h02, r);
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL status_w1c got %h expected 00", r); end
  endtask

  task automatic test_kick_bad();
    logic [7:0] r;
    bus(1'b1, 3'd5, 8'h12, r);
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h02) begin errors++; $display("FAIL kick_bad_idle status=%h expected 02", r); end
    bus(1'b1, 3'd6, 8'h02, r);
    bus(1'b1, 3'd5, 8'h55, r);
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h01) begin errors++; $display("FAIL armed_status got %h expected 01", r); end
    bus(1'b1, 3'd5, 8'h55, r);
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h02) begin errors++; $display("FAIL rearm_error status=%h expected 02", r); end
    bus(1'b1, 3'd6, 8'h02, r);
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    int base;
    base = n_cnt + n_rld + n_cfg;
    bus(1'b1, 3'd5, 8'h55, r);
    @(negedge clk);
    sel = 1'b1; we = 1'b1; addr = 3'd0; wdata = 8'h77; reset = 1'b1;
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || wd_counter_write !== 2'b00 || wd_reload_write !== 2'b00 || wd_config_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid ready=%b cw=%b rw=%b gw=%b expected 0", ready, wd_counter_write, wd_reload_write, wd_config_write);
    end
    reset = 1'b0; sel = 1'b0; we = 1'b0;
    settle();
    checks++;
    if (n_cnt + n_rld + n_cfg - base !== 0) begin
      errors++;
      $display("FAIL reset_mid_strobes got %0d expected 0", n_cnt + n_rld + n_cfg - base);
    end
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL reset_mid_status got %h expected 00", r); end
  endtask

  task automatic test_lock();
    logic [7:0] r;
    int base, cbase;
    base = n_cfg;
    cbase = n_cnt;
    bus(1'b1, 3'd4, 8'h01, r);
    bus(1'b1, 3'd4, 8'h00, r);
    bus(1'b1, 3'd0, 8'h11, r);
    settle();
    bus(1'b0, 3'd6, 8'h00, r);
`ifdef WDT_LOCK_EN
    checks++;
    if (n_cfg - base !== 1 || n_cnt - cbase !== 0 || r !== 8'h04) begin
      errors++;
      $display("FAIL lock cfg=%0d cnt=%0d status=%h expected 1 0 04", n_cfg - base, n_cnt - cbase, r);
    end
    do_reset();
    bus(1'b0, 3'd6, 8'h00, r);
    checks++;
    if (r !== 8'h00) begin errors++; $display("FAIL lock_reset_status got %h expected 00", r); end
    base = n_cfg;
    bus(1'b1, 3'd4, 8'h00, r);
    settle();
    checks++;
    if (n_cfg - base !== 1) begin errors++; $display("FAIL lock_reset_cfg count=%0d expected 1", n_cfg - base); end
`else
    checks++;
    if (n_cfg - base !== 2 || n_cnt - cbase !== 1 || r !== 8'h00 || last_gi !== 8'h00) begin
      errors++;
      $display("FAIL nolock cfg=%0d cnt=%0d status=%h in=%h expected 2 1 00 00", n_cfg - base, n_cnt - cbase, r, last_gi);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_snapshot();
    test_reload();
    test_counter_write();
    test_config();
    test_kick_ok();
    test_kick_boundary();
    test_timeout();
    test_kick_bad();
    test_reset_mid();
    test_lock();
    settle();
    checks++;
    if (n_multi !== 0) begin errors++; $display("FAIL strobe_overlap got %0d cycles expected 0", n_multi); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
